// File: rtl/csidh_seq_pkg.sv
// Shared definitions for the CSIDH-512 limb sequencer.
//   CUSTOM_0      : opcode group of the csidh_ise instructions
//   FUNCT_*       : funct[3:0] encodings of the two multi-limb field ops
//   POS_*         : limb position tag carried in ise_imm[6:4]
//   seq_state_t   : sequencer FSM states
//   limb_pos()    : picks the position tag for a limb
package csidh_seq_pkg;

  localparam logic [1:0] CUSTOM_0     = 2'b00;
  localparam logic [3:0] FUNCT_ANDADD = 4'b0111;
  localparam logic [3:0] FUNCT_SUB    = 4'b0011;

  localparam logic [2:0] POS_FIRST = 3'b001;
  localparam logic [2:0] POS_MID   = 3'b010;
  localparam logic [2:0] POS_LAST  = 3'b100;

  typedef enum logic [2:0] {IDLE, READ, ISSUE, WAIT, DONE, ERR} seq_state_t;

  // The first tag wins so a degenerate single-limb operand still starts a
  // fresh carry chain.
  function automatic logic [2:0] limb_pos(input logic is_first, input logic is_last);
    if (is_first)     return POS_FIRST;
    else if (is_last) return POS_LAST;
    else              return POS_MID;
  endfunction

endpackage

// File: rtl/csidh_seq_tmo.sv
// Wait-state watchdog for csidh_limb_seq (built only with CSIDH_SEQ_TIMEOUT_EN).
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : restart the count (issue cycle)
//   inc        : one waiting cycle elapsed without a datapath result
//   expire     : this waiting cycle is the TMO_CYC-th one without a result
`ifdef CSIDH_SEQ_TIMEOUT_EN
module csidh_seq_tmo #(
  parameter int TMO_CYC = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  localparam int CW = $clog2(TMO_CYC + 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt_q <= '0;
    else if (clr) cnt_q <= '0;
    else if (inc) cnt_q <= cnt_q + CW'(1);
  end

  // A result arriving in the critical cycle holds inc low, so it wins.
  assign expire = inc && (cnt_q == CW'(TMO_CYC - 1));

endmodule
`endif

// File: rtl/csidh_limb_seq.sv
// csidh_limb_seq: walks one multi-limb CSIDH-512 field op (and-add or sub)
// through the csidh_ise datapath, one XLEN-bit limb per step. The datapath
// keeps the carry/borrow chain; this block only orders reads, issues and
// write-backs.
// Ports:
//   ise_clk, ise_rst           : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready/cmd_op : start handshake; cmd_op 0=andadd, 1=sub
//   lmb_re/lmb_raddr           : limb bank read (A and B, data one cycle later)
//   lmb_a/lmb_b                : A/B limbs
//   lmb_we/lmb_waddr/lmb_wdata : result limb write
//   ise_val/ise_fn/ise_imm     : issue strobe, opcode group, {pos, funct}
//   ise_in1/ise_in2            : operands to the datapath
//   ise_oval/ise_out           : datapath result
//   done/err                   : completion pulse, abort pulse (with done)
// Build option: CSIDH_SEQ_TIMEOUT_EN adds a wait watchdog that aborts the
// command after TMO_CYC result-less wait cycles; otherwise err is tied 0.
module csidh_limb_seq
  import csidh_seq_pkg::*;
#(
  parameter int NLIMB   = 8,
  parameter int XLEN    = 64,
  parameter int AW      = 3,
  parameter int TMO_CYC = 15
) (
  input  logic            ise_clk,
  input  logic            ise_rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_op,
  output logic            lmb_re,
  output logic [AW-1:0]   lmb_raddr,
  input  logic [XLEN-1:0] lmb_a,
  input  logic [XLEN-1:0] lmb_b,
  output logic            lmb_we,
  output logic [AW-1:0]   lmb_waddr,
  output logic [XLEN-1:0] lmb_wdata,
  output logic            ise_val,
  output logic [5:0]      ise_fn,
  output logic [6:0]      ise_imm,
  output logic [XLEN-1:0] ise_in1,
  output logic [XLEN-1:0] ise_in2,
  input  logic            ise_oval,
  input  logic [XLEN-1:0] ise_out,
  output logic            done,
  output logic            err
);

  if (NLIMB < 2 || TMO_CYC < 1) begin : g_bad_cfg
    $error("csidh_limb_seq: NLIMB must be >= 2 and TMO_CYC >= 1");
  end

  seq_state_t    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          op_q, op_d;
  logic          last_limb;
  logic          tmo_hit;

  assign last_limb = (idx_q == AW'(NLIMB - 1));
  assign ise_fn    = {4'b0000, CUSTOM_0};

`ifdef CSIDH_SEQ_TIMEOUT_EN
  csidh_seq_tmo #(
    .TMO_CYC (TMO_CYC)
  ) u_tmo (
    .clk    (ise_clk),
    .rst_n  (ise_rst),
    .clr    (state_q == ISSUE),
    .inc    ((state_q == WAIT) && !ise_oval),
    .expire (tmo_hit)
  );
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge ise_clk or negedge ise_rst) begin
    if (!ise_rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      op_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    op_d      = op_q;
    cmd_ready = 1'b0;
    lmb_re    = 1'b0;
    lmb_raddr = '0;
    lmb_we    = 1'b0;
    lmb_waddr = '0;
    lmb_wdata = '0;
    ise_val   = 1'b0;
    ise_imm   = '0;
    ise_in1   = '0;
    ise_in2   = '0;
    done      = 1'b0;
    err       = 1'b0;

    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d    = cmd_op;
          idx_d   = '0;
          state_d = READ;
        end
      end
      READ: begin
        lmb_re    = 1'b1;
        lmb_raddr = idx_q;
        state_d   = ISSUE;
      end
      ISSUE, WAIT: begin
        if (state_q == ISSUE) begin
          ise_val = 1'b1;
          ise_imm = {limb_pos(idx_q == '0, last_limb), op_q ? FUNCT_SUB : FUNCT_ANDADD};
          ise_in1 = lmb_a;
          ise_in2 = lmb_b;
          state_d = WAIT;
        end
        // A same-cycle result in ISSUE is taken exactly as one in WAIT.
        if (ise_oval) begin
          lmb_we    = 1'b1;
          lmb_waddr = idx_q;
          lmb_wdata = ise_out;
          if (last_limb) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + AW'(1);
            state_d = READ;
          end
        end else if (tmo_hit) begin
          state_d = ERR;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      ERR: begin
        done = 1'b1;
`ifdef CSIDH_SEQ_TIMEOUT_EN
        err  = 1'b1;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_csidh_limb_seq.sv
// Scoreboard bench for csidh_limb_seq: stimulus pushes expected issues,
// write-backs and completions; a negedge monitor pops and compares them.
module tb_csidh_limb_seq;

  localparam int NLIMB   = 8;
  localparam int XLEN    = 64;
  localparam int AW      = 3;
  localparam int TMO_CYC = 15;

  logic            ise_clk;
  logic            ise_rst;
  logic            cmd_valid;
  logic            cmd_ready;
  logic            cmd_op;
  logic            lmb_re;
  logic [AW-1:0]   lmb_raddr;
  logic [XLEN-1:0] lmb_a;
  logic [XLEN-1:0] lmb_b;
  logic            lmb_we;
  logic [AW-1:0]   lmb_waddr;
  logic [XLEN-1:0] lmb_wdata;
  logic            ise_val;
  logic [5:0]      ise_fn;
  logic [6:0]      ise_imm;
  logic [XLEN-1:0] ise_in1;
  logic [XLEN-1:0] ise_in2;
  logic            ise_oval;
  logic [XLEN-1:0] ise_out;
  logic            done;
  logic            err;

  csidh_limb_seq #(
    .NLIMB(NLIMB), .XLEN(XLEN), .AW(AW), .TMO_CYC(TMO_CYC)
  ) dut (
    .ise_clk(ise_clk), .ise_rst(ise_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .lmb_re(lmb_re), .lmb_raddr(lmb_raddr), .lmb_a(lmb_a), .lmb_b(lmb_b),
    .lmb_we(lmb_we), .lmb_waddr(lmb_waddr), .lmb_wdata(lmb_wdata),
    .ise_val(ise_val), .ise_fn(ise_fn), .ise_imm(ise_imm),
    .ise_in1(ise_in1), .ise_in2(ise_in2),
    .ise_oval(ise_oval), .ise_out(ise_out),
    .done(done), .err(err)
  );

  initial begin
    ise_clk = 1'b0;
    forever #5 ise_clk = ~ise_clk;
  end

  int cyc = 0;
  initial forever begin
    @(posedge ise_clk);
    cyc++;
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Limb banks: carries, equal operands, borrows and wraps.
  logic [63:0] bank_a [NLIMB] = '{
    64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000, 64'h0123_4567_89AB_CDEF,
    64'h8000_0000_0000_0000, 64'hDEAD_BEEF_0000_0001, 64'h7FFF_FFFF_FFFF_FFFF,
    64'h5555_5555_5555_5555, 64'h0000_0000_0000_00FF};
  logic [63:0] bank_b [NLIMB] = '{
    64'h0000_0000_0000_0001, 64'h0000_0000_0000_0001, 64'hFEDC_BA98_7654_3210,
    64'h8000_0000_0000_0000, 64'h1111_1111_1111_1111, 64'h0000_0000_0000_0001,
    64'hAAAA_AAAA_AAAA_AAAA, 64'h0000_0000_0000_0100};

  always @(posedge ise_clk) begin
    if (lmb_re) begin
      lmb_a <= bank_a[lmb_raddr];
      lmb_b <= bank_b[lmb_raddr];
    end
  end

  // Datapath model: lat=0 answers in the issue cycle, lat=N answers N
  // cycles after ise_val; the limb equal to hang never answers.
  int          lat  = 0;
  int          hang = -1;
  int          cur_limb = 0;
  int          pend = 0;
  logic [63:0] res_q;

  function automatic logic [63:0] dp_f(input logic [63:0] a, input logic [63:0] b,
                                       input logic [6:0] imm);
    case (imm[3:0])
      4'b0111: return a + b;
      4'b0011: return a - b;
      default: return 64'hBAD0_BAD0_BAD0_BAD0;
    endcase
  endfunction

  always @(posedge ise_clk or negedge ise_rst) begin
    if (!ise_rst) begin
      pend <= 0;
    end else begin
      if (lmb_re) cur_limb <= int'(lmb_raddr);
      if (ise_val && lat != 0 && cur_limb != hang) begin
        pend  <= lat;
        res_q <= dp_f(ise_in1, ise_in2, ise_imm);
      end else if (pend != 0) begin
        pend <= pend - 1;
      end
    end
  end

  assign ise_oval = (lat == 0) ? (ise_val && cur_limb != hang) : (pend == 1);
  assign ise_out  = (lat == 0) ? dp_f(ise_in1, ise_in2, ise_imm) : res_q;

  typedef struct {int addr; logic [63:0] data;}                 wr_t;
  typedef struct {logic [6:0] imm; logic [63:0] a; logic [63:0] b;} iss_t;
  typedef struct {logic err; int cyc;}                           dn_t;

  wr_t  exp_wr[$];
  iss_t exp_iss[$];
  dn_t  exp_dn[$];
  int   n_done = 0;
  wr_t  m_w;
  iss_t m_i;
  dn_t  m_d;

  // Monitor
  initial forever begin
    @(negedge ise_clk);
    if (ise_rst) begin
      if (ise_val) begin
        chk("issue_fn", 64'(ise_fn), 64'd0);
        if (exp_iss.size() == 0) begin
          chk("issue_unexpected", 64'(exp_iss.size()), 64'd1);
        end else begin
          m_i = exp_iss.pop_front();
          chk("issue_imm", 64'(ise_imm), 64'(m_i.imm));
          chk("issue_in1", ise_in1, m_i.a);
          chk("issue_in2", ise_in2, m_i.b);
        end
      end
      if (lmb_we) begin
        if (exp_wr.size() == 0) begin
          chk("write_unexpected", 64'(exp_wr.size()), 64'd1);
        end else begin
          m_w = exp_wr.pop_front();
          chk("write_addr", 64'(lmb_waddr), 64'(m_w.addr));
          chk("write_data", lmb_wdata, m_w.data);
        end
      end
      if (done) begin
        n_done++;
        if (exp_dn.size() == 0) begin
          chk("done_unexpected", 64'(exp_dn.size()), 64'd1);
        end else begin
          m_d = exp_dn.pop_front();
          chk("done_err", 64'(err), 64'(m_d.err));
          if (m_d.cyc >= 0) chk("done_cycle", 64'(cyc), 64'(m_d.cyc));
        end
      end else if (err) begin
        chk("err_without_done", 64'(err), 64'd0);
      end
    end
  end

  task automatic push_cmd(input logic op, input int n_iss, input int n_wr,
                          input logic has_done, input logic dn_err, input int dn_cyc);
    logic [2:0] pos;
    for (int i = 0; i < n_iss; i++) begin
      pos = (i == 0) ? 3'b001 : (i == NLIMB - 1) ? 3'b100 : 3'b010;
      exp_iss.push_back('{imm: {pos, op ? 4'b0011 : 4'b0111}, a: bank_a[i], b: bank_b[i]});
    end
    for (int i = 0; i < n_wr; i++)
      exp_wr.push_back('{addr: i, data: op ? bank_a[i] - bank_b[i] : bank_a[i] + bank_b[i]});
    if (has_done) exp_dn.push_back('{err: dn_err, cyc: dn_cyc});
  endtask

  // Called at posedge+1 with the DUT idle; returns the accept cycle.
  task automatic start(input logic op, output int acc);
    cmd_op    = op;
    cmd_valid = 1'b1;
    chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    acc = cyc;
    @(posedge ise_clk); #1;
    cmd_valid = 1'b0;
    chk("cmd_ready_busy", 64'(cmd_ready), 64'd0);
  endtask

  task automatic wait_done(input int target, input int bound);
    for (int k = 0; k < bound && n_done < target; k++) @(posedge ise_clk);
    #1;
    chk("done_count", 64'(n_done), 64'(target));
    chk("issue_q_drained", 64'(exp_iss.size()), 64'd0);
    chk("write_q_drained", 64'(exp_wr.size()), 64'd0);
  endtask

  task automatic chk_quiet(input string name);
    chk({name, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    chk({name, "_outs_zero"}, 64'(|{lmb_re, lmb_raddr, lmb_we, lmb_waddr, lmb_wdata,
        ise_val, ise_fn, ise_imm, ise_in1, ise_in2, done, err}), 64'd0);
  endtask

  int acc;

  initial begin
    ise_rst   = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 1'b0;
    repeat (3) @(posedge ise_clk);
    #1 chk_quiet("reset");
    @(negedge ise_clk) ise_rst = 1'b1;
    @(posedge ise_clk); #1;
    chk_quiet("after_reset");

    // Andadd, same-cycle results: done 17 cycles after accept.
    lat = 0;
    start(1'b0, acc);
    push_cmd(1'b0, NLIMB, NLIMB, 1'b1, 1'b0, acc + 17);
    wait_done(n_done + 1, 40);

    // Sub, results 3 cycles after each issue: 5 cycles per limb.
    lat = 3;
    start(1'b1, acc);
    push_cmd(1'b1, NLIMB, NLIMB, 1'b1, 1'b0, acc + 41);
    wait_done(n_done + 1, 100);

    // cmd_valid held high: op latched at accept, second start right after DONE.
    lat       = 0;
    cmd_op    = 1'b0;
    cmd_valid = 1'b1;
    chk("hold_cmd_ready_idle", 64'(cmd_ready), 64'd1);
    acc = cyc;
    push_cmd(1'b0, NLIMB, NLIMB, 1'b1, 1'b0, acc + 17);
    push_cmd(1'b1, NLIMB, NLIMB, 1'b1, 1'b0, acc + 35);
    @(posedge ise_clk); #1;
    cmd_op = 1'b1;
    chk("hold_busy", 64'(cmd_ready), 64'd0);
    for (int k = 0; k < 40 && n_done < 3; k++) @(posedge ise_clk);
    #1;
    chk("hold_first_done", 64'(n_done), 64'd3);
    chk("hold_rearm_ready", 64'(cmd_ready), 64'd1);
    @(posedge ise_clk); #1;
    cmd_valid = 1'b0;
    chk("hold_second_busy", 64'(cmd_ready), 64'd0);
    wait_done(4, 40);

    // Asynchronous reset while waiting on limb 3.
    lat = 3;
    start(1'b0, acc);
    push_cmd(1'b0, 4, 3, 1'b0, 1'b0, -1);
    for (int k = 0; k < 60 && exp_iss.size() != 0; k++) @(posedge ise_clk);
    #2 ise_rst = 1'b0;
    #1 chk_quiet("async_reset");
    @(posedge ise_clk); #1;
    chk_quiet("reset_next_cycle");
    @(negedge ise_clk) ise_rst = 1'b1;
    repeat (8) @(posedge ise_clk);
    #1;
    chk("rst_writes_0_2_only", 64'(exp_wr.size()), 64'd0);
    chk("rst_issue_q", 64'(exp_iss.size()), 64'd0);
    chk("rst_no_done", 64'(n_done), 64'd4);
    chk("rst_idle_ready", 64'(cmd_ready), 64'd1);

`ifdef CSIDH_SEQ_TIMEOUT_EN
    // Limb 2 never answers: abort after TMO_CYC wait cycles.
    lat  = 0;
    hang = 2;
    start(1'b0, acc);
    push_cmd(1'b0, 3, 2, 1'b1, 1'b1, acc + 6 + TMO_CYC + 1);
    wait_done(n_done + 1, 60);
    hang = -1;

    // Every result lands on the last allowed wait cycle: no abort.
    lat = TMO_CYC;
    start(1'b1, acc);
    push_cmd(1'b1, NLIMB, NLIMB, 1'b1, 1'b0, acc + NLIMB * (TMO_CYC + 2) + 1);
    wait_done(n_done + 1, 200);
`endif

    repeat (2) @(posedge ise_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
